// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// This is the instruction fetch stage that sits just before the decoder.
// - It owns the program counter.
// - It issues one instruction-memory request at a time, using a req/ack
//   handshake.
// - Returned words go into a small prefetch FIFO.
// - The decoder drains the FIFO through a valid/ready interface.
// - A redirect flushes the FIFO and restarts fetch at a new address. If a
//   request is still outstanding, the fetch unit first waits for its ack and
//   throws that data away.
//
// Ports
//   clk_i            clock
//   arst_ni          asynchronous active-low reset
//   boot_addr_i      first fetch address, sampled once when leaving reset
//   imem_req_o       request active at imem_addr_o
//   imem_addr_o      instruction address; held stable until imem_ack_i
//   imem_rdata_i     instruction data, valid with imem_ack_i
//   imem_ack_i       request completed this cycle
//   redirect_i       flush and refetch from redirect_addr_i
//   redirect_addr_i  redirect target
//   instr_valid_o    FIFO head valid
//   instr_ready_i    decoder accepts head this cycle
//   instr_o          head instruction word
//   instr_pc_o       address the head word was fetched from
// -----------------------------------------------------------------------------
package simple_processor_pkg;
  parameter int ADDR_WIDTH = 16;
  parameter int DATA_WIDTH = 16;
endpackage

module instr_fetch_unit #(
  parameter int MEM_ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
  parameter int PC_INC         = 2,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic [MEM_ADDR_WIDTH-1:0] boot_addr_i,
  output logic                      imem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [MEM_DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                      imem_ack_i,
  input  logic                      redirect_i,
  input  logic [MEM_ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                      instr_valid_o,
  input  logic                      instr_ready_i,
  output logic [MEM_DATA_WIDTH-1:0] instr_o,
  output logic [MEM_ADDR_WIDTH-1:0] instr_pc_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]          DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [MEM_ADDR_WIDTH-1:0] INC_C   = MEM_ADDR_WIDTH'(PC_INC);

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_STALL,
    S_DRAIN
  } state_e;

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [MEM_ADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic                      req_q, req_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [MEM_DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [MEM_DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
  logic [MEM_ADDR_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [MEM_ADDR_WIDTH-1:0] fifo_pc_d   [FIFO_DEPTH];

  logic ack_fire;
  logic flush;
  logic push;
  logic pop;
  logic valid;

  assign valid    = (cnt_q != '0);
  // An ack that arrives while no request is active has no meaning, so it is ignored.
  assign ack_fire = req_q & imem_ack_i;
  // Redirect is meaningless before the PC has been loaded from boot_addr_i.
  assign flush    = redirect_i & (state_q != S_BOOT);
  assign push     = ack_fire & (state_q == S_FETCH) & ~flush;
  assign pop      = valid & instr_ready_i & ~flush;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_data_d = fifo_data_q;
    fifo_pc_d   = fifo_pc_q;

    if (flush) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
        fifo_data_d[wr_ptr_q] = imem_rdata_i;
        fifo_pc_d[wr_ptr_q]   = pc_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
    end

    unique case (state_q)
      S_BOOT: begin
        pc_d    = boot_addr_i;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (flush) begin
          if (ack_fire) begin
            // The word for the old path arrived together with the redirect.
            // Drop it and start the new path straight away.
            pc_d = redirect_addr_i;
          end else begin
            tgt_d   = redirect_addr_i;
            state_d = S_DRAIN;
          end
        end else if (ack_fire) begin
          pc_d    = pc_q + INC_C;
          state_d = (cnt_d < DEPTH_C) ? S_FETCH : S_STALL;
        end
      end
      S_STALL: begin
        if (flush) begin
          pc_d    = redirect_addr_i;
          state_d = S_FETCH;
        end else if (cnt_d < DEPTH_C) begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        // The redirected request is still in flight. Keep it stable until it
        // completes, then throw its data away. The newest target wins.
        if (flush) begin
          tgt_d = redirect_addr_i;
        end
        if (ack_fire) begin
          pc_d    = flush ? redirect_addr_i : tgt_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase

    req_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= S_BOOT;
      pc_q     <= '0;
      tgt_q    <= '0;
      req_q    <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_data_q <= fifo_data_d;
      fifo_pc_q   <= fifo_pc_d;
    end
  end

  // The PC register is the request address. It only advances on an ack, so
  // the address stays stable while a request waits for its ack.
  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid;
  assign instr_o       = fifo_data_q[rd_ptr_q];
  assign instr_pc_o    = fifo_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit.
// - The bench plays the instruction memory. A returned word is a fixed
//   function of its address.
// - Each word the memory acks is queued as an expected decoder delivery.
// - The queue is emptied on a redirect.
// - Every word the decoder accepts is compared against the head of the queue.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic [15:0] boot_addr_i;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic [15:0] imem_rdata_i;
  logic        imem_ack_i;
  logic        redirect_i;
  logic [15:0] redirect_addr_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [15:0] instr_o;
  logic [15:0] instr_pc_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] sb[$];
  bit          drain   = 1'b0;

  always #5 clk_i = ~clk_i;

  instr_fetch_unit #(
    .MEM_ADDR_WIDTH(16),
    .MEM_DATA_WIDTH(16),
    .PC_INC        (2),
    .FIFO_DEPTH    (2)
  ) dut (
    .clk_i          (clk_i),
    .arst_ni        (arst_ni),
    .boot_addr_i    (boot_addr_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_rdata_i   (imem_rdata_i),
    .imem_ack_i     (imem_ack_i),
    .redirect_i     (redirect_i),
    .redirect_addr_i(redirect_addr_i),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .instr_o        (instr_o),
    .instr_pc_o     (instr_pc_o)
  );

  function automatic logic [15:0] dat_of(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and update the scoreboard with what this cycle
  // should mean. Then advance to 1 time unit after the next rising edge.
  task automatic tick(input logic ack, input logic rdy, input logic rd, input logic [15:0] ra);
    logic [15:0] exp_pc;
    imem_ack_i      = ack;
    imem_rdata_i    = ack ? dat_of(imem_addr_o) : 16'h0000;
    instr_ready_i   = rdy;
    redirect_i      = rd;
    redirect_addr_i = ra;
    if (rd) begin
      sb.delete();
      drain = imem_req_o && !ack;
    end else begin
      if (instr_valid_o && rdy) begin
        chk("pop_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_pc = sb.pop_front();
          chk("pop_pc", instr_pc_o, exp_pc);
          chk("pop_data", instr_o, dat_of(exp_pc));
        end
      end
      if (ack && imem_req_o) begin
        if (drain) drain = 1'b0;
        else sb.push_back(imem_addr_o);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] boot);
    arst_ni         = 1'b0;
    boot_addr_i     = boot;
    imem_ack_i      = 1'b0;
    imem_rdata_i    = 16'h0000;
    redirect_i      = 1'b0;
    redirect_addr_i = 16'h0000;
    instr_ready_i   = 1'b0;
    sb.delete();
    drain = 1'b0;
    #1;
    chk("rst_req", imem_req_o, 0);
    chk("rst_addr", imem_addr_o, 0);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_pc", instr_pc_o, 0);
    @(posedge clk_i);
    #1;
    arst_ni = 1'b1;
  endtask

  initial begin
    arst_ni         = 1'b0;
    boot_addr_i     = 16'h0100;
    imem_ack_i      = 1'b0;
    imem_rdata_i    = 16'h0000;
    redirect_i      = 1'b0;
    redirect_addr_i = 16'h0000;
    instr_ready_i   = 1'b0;
    @(posedge clk_i);
    #1;

    // Boot with zero-wait memory and an always-ready decoder.
    do_reset(16'h0100);
    chk("boot_req_low", imem_req_o, 0);
    tick(1, 1, 0, 16'h0);
    chk("boot_req", imem_req_o, 1);
    chk("boot_addr", imem_addr_o, 16'h0100);
    chk("boot_valid_lat", instr_valid_o, 0);
    tick(1, 1, 0, 16'h0);
    chk("seq_valid", instr_valid_o, 1);
    chk("seq_pc0", instr_pc_o, 16'h0100);
    chk("seq_addr1", imem_addr_o, 16'h0102);
    tick(1, 1, 0, 16'h0);
    chk("seq_pc1", instr_pc_o, 16'h0102);
    tick(1, 1, 0, 16'h0);
    chk("seq_pc2", instr_pc_o, 16'h0104);

    // Backpressure: the FIFO fills and fetch stops with the PC at 0x0104.
    do_reset(16'h0100);
    tick(1, 0, 0, 16'h0);
    tick(1, 0, 0, 16'h0);
    tick(1, 0, 0, 16'h0);
    chk("bp_req_low", imem_req_o, 0);
    chk("bp_addr_hold", imem_addr_o, 16'h0104);
    chk("bp_head", instr_pc_o, 16'h0100);
    tick(1, 0, 0, 16'h0);
    chk("bp_req_still_low", imem_req_o, 0);
    chk("bp_head_hold", instr_pc_o, 16'h0100);
    chk("bp_data_hold", instr_o, dat_of(16'h0100));
    tick(1, 1, 0, 16'h0);
    chk("bp_resume_req", imem_req_o, 1);
    chk("bp_resume_addr", imem_addr_o, 16'h0104);
    chk("bp_head2", instr_pc_o, 16'h0102);
    tick(1, 1, 0, 16'h0);
    chk("bp_head3", instr_pc_o, 16'h0104);
    chk("bp_addr_next", imem_addr_o, 16'h0106);
    tick(0, 1, 0, 16'h0);

    // Wait states: the memory acks on the fourth cycle of the request.
    for (int i = 0; i < 4; i++) begin
      chk("ws_req", imem_req_o, 1);
      chk("ws_addr", imem_addr_o, 16'h0106);
      chk("ws_valid", instr_valid_o, 0);
      tick((i == 3), 1, 0, 16'h0);
    end
    chk("ws_valid_after_ack", instr_valid_o, 1);
    chk("ws_pc", instr_pc_o, 16'h0106);
    chk("ws_addr_next", imem_addr_o, 16'h0108);

    // Redirect while the request at 0x0108 is still waiting for its ack.
    tick(0, 1, 1, 16'h0200);
    chk("rd_flush_valid", instr_valid_o, 0);
    chk("rd_drain_req", imem_req_o, 1);
    chk("rd_drain_addr", imem_addr_o, 16'h0108);
    tick(0, 1, 0, 16'h0);
    chk("rd_drain_addr2", imem_addr_o, 16'h0108);
    chk("rd_drain_valid", instr_valid_o, 0);
    tick(1, 1, 0, 16'h0);
    chk("rd_new_addr", imem_addr_o, 16'h0200);
    chk("rd_dropped_word", instr_valid_o, 0);
    tick(1, 1, 0, 16'h0);
    chk("rd_first_pc", instr_pc_o, 16'h0200);
    chk("rd_addr_next", imem_addr_o, 16'h0202);

    // Redirect, ack and pop all in the same cycle.
    tick(1, 1, 1, 16'h0300);
    chk("co_valid", instr_valid_o, 0);
    chk("co_req", imem_req_o, 1);
    chk("co_addr", imem_addr_o, 16'h0300);
    tick(1, 1, 0, 16'h0);
    chk("co_first_pc", instr_pc_o, 16'h0300);
    tick(0, 1, 0, 16'h0);

    // The address wraps past 0xFFFE.
    do_reset(16'hFFFE);
    tick(1, 1, 0, 16'h0);
    chk("wrap_boot_addr", imem_addr_o, 16'hFFFE);
    tick(1, 1, 0, 16'h0);
    chk("wrap_addr", imem_addr_o, 16'h0000);
    chk("wrap_pc", instr_pc_o, 16'hFFFE);
    tick(0, 1, 0, 16'h0);
    tick(0, 1, 0, 16'h0);
    chk("mid_wait_req", imem_req_o, 1);

    // Reset in the middle of a wait. A late ack after release must be ignored.
    do_reset(16'hFFFE);
    tick(1, 1, 0, 16'h0);
    chk("late_ack_valid", instr_valid_o, 0);
    chk("late_ack_addr", imem_addr_o, 16'hFFFE);
    tick(0, 1, 0, 16'h0);
    chk("late_ack_valid2", instr_valid_o, 0);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
